// File: rtl/dcache_mem_pkg.sv
// Shared types and constants for the data-cache memory responder.
package dcache_mem_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 64;
  localparam int LATENCY_MAX = 15;
  // Wide enough to count up to LATENCY_MAX.
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    TURN = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_mem_array.sv
// Word storage behind the responder: one synchronous write port and one
// read port with a registered output that holds its value between reads.
// The array itself is never reset; only the read output register is.
module dcache_mem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Write port: storage contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port: loads only on a read, otherwise keeps the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dcache_mem_responder.sv
// Fixed-latency memory model answering data-cache requests.
// One transaction at a time: IDLE -> WAIT (LATENCY-1 cycles) -> ACK -> TURN.
// A backdoor preload port writes storage while idle and no request is pending.
// Optional macro DCACHE_MEM_RESP_STATS_EN adds saturating rd_count/wr_count.
module dcache_mem_responder
  import dcache_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_req,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_ack,
  output logic [DATA_W-1:0]        mem_rdata,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
`ifdef DCACHE_MEM_RESP_STATS_EN
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count,
`endif
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(DATA_W / 8);
  // WAIT exits once the counter reaches this value (counter starts at 1).
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LATENCY - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               write_reg, write_next;
  logic [DATA_W-1:0]  wdata_reg, wdata_next;

  logic [IDX_W-1:0]   req_idx;
  logic               enter_ack;
  logic               load_fire;
  logic               arr_we;
  logic               arr_re;
  logic [IDX_W-1:0]   arr_waddr;
  logic [DATA_W-1:0]  arr_wdata;
  logic               unused_addr;

  // Byte address to word index; bits above the index alias.
  assign req_idx     = mem_addr[OFF_W +: IDX_W];
  assign unused_addr = ^mem_addr;

  // Next-state, latency counter and request capture.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    write_next = write_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          idx_next   = req_idx;
          write_next = mem_write;
          wdata_next = mem_wdata;
          cnt_next   = CNT_W'(1);
          state_next = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ACK: begin
        state_next = TURN;
      end
      TURN: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and captured request registers; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      write_reg <= write_next;
      wdata_reg <= wdata_next;
    end
  end

  // The edge entering ACK is where the transaction touches storage. The
  // *_next values are the live inputs when LATENCY=1 (entry from IDLE) and
  // the captured copies otherwise.
  assign enter_ack = (state_next == ACK) && (state_reg != ACK) && !rst;
  assign ld_ready  = (state_reg == IDLE) && !mem_req;
  assign load_fire = ld_valid && ld_ready;

  // Commit and preload never coincide: commit needs a request or a
  // non-IDLE state, preload needs IDLE with no request.
  assign arr_we    = (enter_ack && write_next) || load_fire;
  assign arr_waddr = enter_ack ? idx_next : ld_idx;
  assign arr_wdata = enter_ack ? wdata_next : ld_data;
  assign arr_re    = enter_ack && !write_next;

  dcache_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (idx_next),
    .rdata (mem_rdata)
  );

  assign mem_ack = (state_reg == ACK);
  assign busy    = (state_reg != IDLE);

`ifdef DCACHE_MEM_RESP_STATS_EN
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;

  // Saturating per-type completion counters, bumped during the ACK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (state_reg == ACK) begin
      if (write_reg) begin
        if (wr_count_reg != '1) wr_count_reg <= wr_count_reg + 32'd1;
      end else begin
        if (rd_count_reg != '1) rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed testbench for dcache_mem_responder (LATENCY=4, 64-bit words).
module tb_dcache_mem_responder;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic              mem_write = 1'b0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              ld_valid = 1'b0;
  logic [9:0]        ld_idx = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              busy;
`ifdef DCACHE_MEM_RESP_STATS_EN
  logic [31:0]       rd_count;
  logic [31:0]       wr_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ld_valid  (ld_valid),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
`ifdef DCACHE_MEM_RESP_STATS_EN
    .rd_count  (rd_count),
    .wr_count  (wr_count),
`endif
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
  endtask

  // One-cycle backdoor preload; returns ld_ready as seen before the edge.
  task automatic preload(input logic [9:0] idx, input logic [63:0] data, output logic rdy);
    ld_idx   = idx;
    ld_data  = data;
    ld_valid = 1'b1;
    #1;
    rdy = ld_ready;
    tick();
    ld_valid = 1'b0;
    $display("preload idx=%0d data=%h ready=%b", idx, data, rdy);
  endtask

  // Full transaction. Inputs are scrambled right after acceptance to show
  // they are not used. lat is the cycle (1-based after the acceptance edge)
  // in which ack appeared, 0 on timeout; turn_ack is ack in the next cycle.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                        output int lat, output logic [63:0] rd, output logic turn_ack);
    wait_idle();
    mem_req   = 1'b1;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    tick();
    mem_write = ~wr;
    mem_addr  = ~addr;
    mem_wdata = ~wd;
    lat = 0;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_ack) begin
        lat = c;
        rd  = mem_rdata;
        break;
      end
      tick();
    end
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tick();
    turn_ack = mem_ack;
    tick();
    $display("txn %s addr=%h wdata=%h lat=%0d rdata=%h", wr ? "WR" : "RD", addr, wd, lat, rd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", mem_ack); end
    checks++; if (mem_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_preload_read();
    logic rdy, ta;
    int lat;
    logic [63:0] rd;
    preload(10'd5, 64'hDEAD_BEEF_0000_0005, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL preload_ready: got %b expected 1", rdy); end
    do_txn(1'b0, 32'h28, 64'h0, lat, rd, ta);
    checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL read_data: got %h expected deadbeef00000005", rd); end
    checks++; if (ta !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", ta); end
    checks++; if (mem_rdata !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef00000005", mem_rdata); end
    // Bit 20 lies above the index field, so this aliases to index 5.
    do_txn(1'b0, 32'h0010_0028, 64'h0, lat, rd, ta);
    checks++; if (rd !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL alias_read: got %h expected deadbeef00000005", rd); end
  endtask

  task automatic test_write_read();
    logic ta;
    int lat;
    logic [63:0] rd;
    do_txn(1'b1, 32'h40, 64'h1122_3344_5566_7788, lat, rd, ta);
    checks++; if (lat !== 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL write_ack_rdata: got %h expected deadbeef00000005", rd); end
    do_txn(1'b0, 32'h40, 64'h0, lat, rd, ta);
    checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL read_after_write: got %h expected 1122334455667788", rd); end
  endtask

  task automatic test_back_to_back();
    int t_ack [3];
    int n = 0;
    wait_idle();
    mem_req   = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h40;
    for (int t = 1; t <= 40 && n < 3; t++) begin
      tick();
      if (mem_ack) begin
        t_ack[n] = t;
        n++;
      end
    end
    checks++; if (mem_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL b2b_rdata: got %h expected 1122334455667788", mem_rdata); end
    mem_req  = 1'b0;
    mem_addr = '0;
    wait_idle();
    $display("b2b acks=%0d times=%0d,%0d,%0d", n, t_ack[0], t_ack[1], t_ack[2]);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n); end
    checks++; if (t_ack[0] !== 4) begin errors++; $display("FAIL b2b_first: got %0d expected 4", t_ack[0]); end
    checks++; if (t_ack[1] - t_ack[0] !== LATENCY + 2) begin errors++; $display("FAIL b2b_gap1: got %0d expected 6", t_ack[1] - t_ack[0]); end
    checks++; if (t_ack[2] - t_ack[1] !== LATENCY + 2) begin errors++; $display("FAIL b2b_gap2: got %0d expected 6", t_ack[2] - t_ack[1]); end
  endtask

  task automatic test_ld_conflict();
    logic rdy, ta, rdy_conf;
    int lat;
    logic [63:0] rd;
    preload(10'd7, 64'h1111, rdy);
    wait_idle();
    mem_req   = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h38;
    ld_valid  = 1'b1;
    ld_idx    = 10'd7;
    ld_data   = 64'h2222;
    #1;
    rdy_conf = ld_ready;
    tick();
    ld_valid = 1'b0;
    $display("conflict req+preload idx=7 ld_ready=%b busy=%b", rdy_conf, busy);
    checks++; if (rdy_conf !== 1'b0) begin errors++; $display("FAIL conflict_ld_ready: got %b expected 0", rdy_conf); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conflict_accept: got %b expected 1", busy); end
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_ack) begin
        lat = c;
        rd  = mem_rdata;
        break;
      end
      tick();
    end
    mem_req = 1'b0;
    checks++; if (lat !== 4) begin errors++; $display("FAIL conflict_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 64'h1111) begin errors++; $display("FAIL conflict_rdata: got %h expected 1111", rd); end
    do_txn(1'b0, 32'h38, 64'h0, lat, rd, ta);
    checks++; if (rd !== 64'h1111) begin errors++; $display("FAIL preload_blocked: got %h expected 1111", rd); end
  endtask

  task automatic test_reset_abort();
    logic rdy, ta;
    int lat, acks;
    logic [63:0] rd;
    preload(10'd3, 64'h0, rdy);
    wait_idle();
    mem_req   = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 32'h18;
    mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    rst     = 1'b1;
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    $display("abort write idx=3 by reset, busy=%b", busy);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", busy); end
    checks++; if (mem_rdata !== 64'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", mem_rdata); end
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_ack) acks++;
      tick();
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d expected 0", acks); end
    do_txn(1'b0, 32'h18, 64'h0, lat, rd, ta);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL abort_no_commit: got %h expected 0", rd); end
  endtask

`ifdef DCACHE_MEM_RESP_STATS_EN
  task automatic test_stats();
    logic ta;
    int lat;
    logic [63:0] rd;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_txn(1'b0, 32'h28, 64'h0, lat, rd, ta);
    for (int i = 0; i < 2; i++) do_txn(1'b1, 32'h50, 64'h5, lat, rd, ta);
    checks++; if (rd_count !== 32'd3) begin errors++; $display("FAIL stats_rd: got %0d expected 3", rd_count); end
    checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL stats_wr: got %0d expected 2", wr_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL stats_rd_reset: got %0d expected 0", rd_count); end
    checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL stats_wr_reset: got %0d expected 0", wr_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_back_to_back();
    test_ld_conflict();
    test_reset_abort();
`ifdef DCACHE_MEM_RESP_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
